// File: rtl/prefix_adder_pipe.sv
// Pipelined Sklansky parallel-prefix adder/subtractor with SIMD lane partitioning.
//
// The operand stage forms generate/propagate, inverts B for subtraction and injects the
// lane carry-in at the bottom bit of every lane. The log2(WIDTH) prefix levels are split
// into segments of LEVELS_PER_REG levels, each followed by a register. A final output
// register holds sum, per-slot carry-out/overflow and the tag. A result appears L =
// 1 + ceil(log2(WIDTH)/LEVELS_PER_REG) clock edges after the edge that accepts it.
// A single enable stalls the whole pipe while the output is held and not consumed.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operation handshake
//   in_a, in_b            operands
//   in_cin, in_sub        carry-in (per lane), subtract select (forces carry-in 1)
//   in_lane               0: full width, 1: 16-bit lanes, 2: 8-bit lanes, 3: full width
//   in_tag                opaque tag returned with the result
//   out_valid/out_ready   result handshake
//   out_sum               sum or difference
//   out_cout, out_ovf     carry-out / signed overflow per 8-bit slot, only at lane tops
//   out_tag               tag of the result
module prefix_adder_pipe #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned LEVELS_PER_REG = 2,
  parameter int unsigned TAG_W          = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_cin,
  input  logic                 in_sub,
  input  logic [1:0]           in_lane,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_sum,
  output logic [WIDTH/8-1:0]   out_cout,
  output logic [WIDTH/8-1:0]   out_ovf,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned LOG   = $clog2(WIDTH);
  localparam int unsigned NSEG  = (LOG + LEVELS_PER_REG - 1) / LEVELS_PER_REG;
  localparam int unsigned NST   = NSEG + 1;
  localparam int unsigned SLOTS = WIDTH / 8;

  logic en;
  logic out_vld_q;

  assign en       = !out_vld_q || out_ready;
  assign in_ready = en;

  // Lane-bottom patterns; a lane wider than WIDTH degenerates to the single-lane pattern.
  logic [WIDTH-1:0] lsb_one, lsb_8, lsb_16;
  for (genvar i = 0; i < WIDTH; i++) begin : g_lsb
    assign lsb_one[i] = (i == 0);
    assign lsb_8[i]   = (i % 8 == 0);
    assign lsb_16[i]  = (i % 16 == 0);
  end

  // Operand stage
  logic [WIDTH-1:0] b_eff, op_g, op_p, lane_lsb;
  logic             op_cin;

  always_comb begin
    unique case (in_lane)
      2'd1:    lane_lsb = lsb_16;
      2'd2:    lane_lsb = lsb_8;
      default: lane_lsb = lsb_one;
    endcase
    b_eff  = in_sub ? ~in_b : in_b;
    op_p   = in_a ^ b_eff;
    op_cin = in_sub | in_cin;
    op_g   = (in_a & b_eff) | (op_p & {WIDTH{op_cin}} & lane_lsb);
  end

  // Stage s register holds the prefix state after s segments. Stage NSEG needs no P.
  logic [WIDTH-1:0] st_g_q   [NST];
  logic [WIDTH-1:0] st_g_d   [NST];
  logic [WIDTH-1:0] st_p_q   [NSEG];
  logic [WIDTH-1:0] st_p_d   [NSEG];
  logic [WIDTH-1:0] st_hs_q  [NST];  // original propagate (half sum)
  logic [WIDTH-1:0] st_hs_d  [NST];
  logic [WIDTH-1:0] st_cm_q  [NST];  // combine mask: 0 at lane bottoms
  logic [WIDTH-1:0] st_cm_d  [NST];
  logic             st_cin_q [NST];
  logic             st_cin_d [NST];
  logic [TAG_W-1:0] st_tag_q [NST];
  logic [TAG_W-1:0] st_tag_d [NST];
  logic [NST-1:0]   st_vld_q, st_vld_d;

  // Prefix levels. A right operand across a lane bottom contributes g=0, p=0.
  for (genvar k = 0; k < LOG; k++) begin : g_lvl
    localparam int unsigned S = k / LEVELS_PER_REG;
    logic [WIDTH-1:0] g_in, p_in, cm, g_out, p_out;
    assign cm = st_cm_q[S];
    if (k % LEVELS_PER_REG == 0) begin : g_from_reg
      assign g_in = st_g_q[S];
      assign p_in = st_p_q[S];
    end else begin : g_from_lvl
      assign g_in = g_lvl[k-1].g_out;
      assign p_in = g_lvl[k-1].p_out;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i >> k) & 1) == 1) begin : g_comb
        localparam int J = ((i >> k) << k) - 1;
        assign g_out[i] = g_in[i] | (p_in[i] & g_in[J] & cm[J+1]);
        assign p_out[i] = p_in[i] & p_in[J] & cm[J+1];
      end else begin : g_pass
        assign g_out[i] = g_in[i];
        assign p_out[i] = p_in[i];
      end
    end
  end

  for (genvar s = 0; s < NST; s++) begin : g_st_d
    if (s == 0) begin : g_first
      assign st_vld_d[0] = in_valid;
      assign st_g_d[0]   = op_g;
      assign st_p_d[0]   = op_p;
      assign st_hs_d[0]  = op_p;
      assign st_cm_d[0]  = ~lane_lsb;
      assign st_cin_d[0] = op_cin;
      assign st_tag_d[0] = in_tag;
    end else begin : g_next
      localparam int unsigned KEND = ((s * LEVELS_PER_REG) < LOG) ?
                                     (s * LEVELS_PER_REG) - 1 : LOG - 1;
      assign st_vld_d[s] = st_vld_q[s-1];
      assign st_g_d[s]   = g_lvl[KEND].g_out;
      if (s < NSEG) begin : g_p
        assign st_p_d[s] = g_lvl[KEND].p_out;
      end
      assign st_hs_d[s]  = st_hs_q[s-1];
      assign st_cm_d[s]  = st_cm_q[s-1];
      assign st_cin_d[s] = st_cin_q[s-1];
      assign st_tag_d[s] = st_tag_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_vld_q <= '0;
      for (int s = 0; s < NST; s++) begin
        st_g_q[s]   <= '0;
        st_hs_q[s]  <= '0;
        st_cm_q[s]  <= '0;
        st_cin_q[s] <= 1'b0;
        st_tag_q[s] <= '0;
      end
      for (int s = 0; s < NSEG; s++) begin
        st_p_q[s] <= '0;
      end
    end else if (en) begin
      st_vld_q <= st_vld_d;
      for (int s = 0; s < NST; s++) begin
        if (st_vld_d[s]) begin
          st_g_q[s]   <= st_g_d[s];
          st_hs_q[s]  <= st_hs_d[s];
          st_cm_q[s]  <= st_cm_d[s];
          st_cin_q[s] <= st_cin_d[s];
          st_tag_q[s] <= st_tag_d[s];
        end
      end
      for (int s = 0; s < NSEG; s++) begin
        if (st_vld_d[s]) st_p_q[s] <= st_p_d[s];
      end
    end
  end

  // Sum and flags from the final prefix state
  logic [WIDTH-1:0] g_last, cm_last, carry, msb, sum_d;
  logic [SLOTS-1:0] cout_d, ovf_d;

  always_comb begin
    g_last  = st_g_q[NSEG];
    cm_last = st_cm_q[NSEG];
    // Carry into bit i: G of the bit below inside a lane, the lane carry-in at its bottom.
    carry   = (cm_last & {g_last[WIDTH-2:0], 1'b0}) | (~cm_last & {WIDTH{st_cin_q[NSEG]}});
    sum_d   = st_hs_q[NSEG] ^ carry;
    msb     = {1'b1, ~cm_last[WIDTH-1:1]};
  end

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    assign cout_d[s] = msb[8*s+7] & g_last[8*s+7];
    assign ovf_d[s]  = msb[8*s+7] & (g_last[8*s+7] ^ g_last[8*s+6]);
  end

  logic [WIDTH-1:0] out_sum_q;
  logic [SLOTS-1:0] out_cout_q, out_ovf_q;
  logic [TAG_W-1:0] out_tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_sum_q  <= '0;
      out_cout_q <= '0;
      out_ovf_q  <= '0;
      out_tag_q  <= '0;
    end else if (en) begin
      out_vld_q <= st_vld_q[NSEG];
      if (st_vld_q[NSEG]) begin
        out_sum_q  <= sum_d;
        out_cout_q <= cout_d;
        out_ovf_q  <= ovf_d;
        out_tag_q  <= st_tag_q[NSEG];
      end
    end
  end

  assign out_valid = out_vld_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_tag   = out_tag_q;

endmodule

// File: doc/prefix_adder_pipe.md
# prefix_adder_pipe

Parametrised, pipelined parallel-prefix (Sklansky) adder/subtractor for the ALU datapath. It generalises the single masked prefix stage into a complete adder with configurable width, register placement and SIMD lane partitioning. Lane boundaries are enforced by masking generate/propagate across boundaries. Operations enter and leave through valid/ready handshakes, carry a tag, and produce per-lane carry-out and signed-overflow flags.

## Interface
- WIDTH, 32: operand width; power of two, 8..64.
- LEVELS_PER_REG, 2: prefix levels between pipeline registers; 1..log2(WIDTH).
- TAG_W, 4: opaque tag width carried alongside each operation.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation present.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in, applied to every lane (ignored when in_sub=1).
- in_sub  in  1  1: A - B (B inverted, carry-in forced to 1 per lane).
- in_lane  in  2  0: one WIDTH lane; 1: 16-bit lanes; 2: 8-bit lanes; 3: reserved, treated as 0.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_sum  out  WIDTH  sum/difference.
- out_cout  out  WIDTH/8  carry-out per 8-bit slot; set only in the top slot of each lane.
- out_ovf  out  WIDTH/8  signed overflow per 8-bit slot; same placement as out_cout.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Operand stage: B' = in_sub ? ~B : B; g = A & B', p = A ^ B'. Lane carry-in = in_sub | in_cin, injected at bit 0 of each lane as g0' = g0 | (p0 & cin_lane).
- Lane mask: bit i is cleared in the combine mask when bit i is the lowest bit of a lane. At each prefix level, a right operand crossing a lane boundary contributes g=0, p=0, so carries never cross lanes.
- Prefix: log2(WIDTH) Sklansky levels. Level k combines bit i with bit (i | (2^k − 1)) − 2^k, rounded down to its group, for every bit in the upper half of each 2^(k+1) group. Other bits pass through.
- Sum: s_i = p_i ^ G_(i−1) within a lane; G at the bottom bit of a lane is the lane carry-in.
- cout(lane) = G at lane msb. ovf(lane) = carry into msb XOR carry out of msb. With in_sub, cout=1 means no borrow.
- in_lane selecting a lane wider than WIDTH is equivalent to 0. WIDTH=8 ignores in_lane.

## Timing
- Latency L = 1 + ceil(log2(WIDTH)/LEVELS_PER_REG) cycles from the accept edge to out_valid. WIDTH=32 and LEVELS_PER_REG=2 give L=4.
- Stall: one global enable, en = !out_valid || out_ready. All pipeline registers, including valid bits, advance only when en=1. in_ready = en.
- Throughput is one operation per cycle when out_ready stays high. Bubbles are not collapsed while stalled.
- Data and tag registers load only when their valid is set. Results are held stable while out_valid && !out_ready.
- Reset: all valid bits clear immediately. out_valid=0. out_sum, out_cout, out_ovf and out_tag are 0. in_ready=1 in the first cycle after rst falls.
- Reset mid-flight discards every in-progress operation; no result appears after reset.
- Simultaneous input accept and output consume in the same cycle are both honoured.

## Test plan
- WIDTH=32, lane 0, A=0xFFFFFFFF, B=0x00000001, cin=0 -> 4 cycles later: sum=0x00000000, cout=4'b1000, ovf=4'b0000.
- Lane 2, A=0x7FFF0180, B=0x01010180 -> sum=0x80000200, cout=4'b0101, ovf=4'b1001.
- Subtract, lane 0, A=5, B=7 -> sum=0xFFFFFFFE, cout=4'b0000, ovf=4'b0000. Subtract, A=7, B=5 -> sum=2, cout=4'b1000.
- Lane 1, A=0x0000FFFF, B=0, cin=1 -> sum=0x00010000, cout=4'b0010. The same operands in lane 0 -> sum=0x00010000, cout=4'b0000.
- Eight back-to-back ops with tags 0..7, out_ready held low for 3 cycles mid-stream -> in_ready low during the stall; all 8 results arrive in tag order with no loss or duplication; outputs stable while stalled.
- Assert rst with 3 ops in flight -> out_valid drops the same cycle. After release, no stale results appear and a new op returns after exactly L cycles.
